// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC/NPC with one delay slot, IF/ID register, and a
// memory handshake FSM that parks a returned instruction while the pipe is stalled.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        LE,
  input  logic        BR_TAKEN,
  input  logic [31:0] TA,
  input  logic        NULLIFY,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_DATA,
  input  logic        IMEM_READY,
  output logic [31:0] PC,
  output logic [31:0] NPC,
  output logic [31:0] ID_INSTR,
  output logic [31:0] ID_PC,
  output logic        ID_VALID
);

  // state | meaning
  // FETCH | request issued for PC, no response seen yet this fetch
  // WAIT  | memory has not answered, request held on PC
  // HOLD  | response captured in hold buffer, waiting for LE
  typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;

  state_t      state, next_state;
  logic [31:0] pc_q, npc_q;
  logic [31:0] id_instr_q, id_pc_q;
  logic        id_valid_q;
  logic [31:0] hold_instr, hold_pc;
  logic        redir_pend, squash_pend;
  logic [31:0] redir_ta;
  logic        imem_req_q;

  logic        advance, do_redir, do_squash;
  logic [31:0] redir_tgt, load_instr, load_pc;

  always_comb begin
    advance    = LE && ((state == HOLD) || IMEM_READY);
    do_redir   = BR_TAKEN || redir_pend;
    redir_tgt  = BR_TAKEN ? TA : redir_ta;
    do_squash  = NULLIFY || squash_pend;
    load_instr = (state == HOLD) ? hold_instr : IMEM_DATA;
    load_pc    = (state == HOLD) ? hold_pc : pc_q;
    next_state = state;
    if (advance)
      next_state = FETCH;
    else if (state != HOLD)
      next_state = IMEM_READY ? HOLD : WAIT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc_q        <= RESET_PC;
      npc_q       <= RESET_PC + 32'd4;
      id_instr_q  <= '0;
      id_pc_q     <= '0;
      id_valid_q  <= 1'b0;
      hold_instr  <= '0;
      hold_pc     <= '0;
      redir_pend  <= 1'b0;
      redir_ta    <= '0;
      squash_pend <= 1'b0;
      imem_req_q  <= 1'b1;
    end else begin
      state      <= next_state;
      imem_req_q <= (next_state != HOLD);
      if (advance) begin
        pc_q        <= npc_q;
        npc_q       <= do_redir ? redir_tgt : npc_q + 32'd4;
        redir_pend  <= 1'b0;
        id_instr_q  <= do_squash ? 32'd0 : load_instr;
        id_valid_q  <= !do_squash;
        id_pc_q     <= load_pc;
        squash_pend <= 1'b0;
      end else begin
        if (BR_TAKEN) begin
          redir_pend <= 1'b1;
          redir_ta   <= TA;
        end
        if (NULLIFY)
          squash_pend <= 1'b1;
        if (state != HOLD) begin
          if (IMEM_READY) begin
            hold_instr <= IMEM_DATA;
            hold_pc    <= pc_q;
          end else if (LE) begin
            // bubble keeps ID_PC and leaves any pending squash armed
            id_instr_q <= '0;
            id_valid_q <= 1'b0;
          end
        end
      end
    end
  end

  assign IMEM_REQ  = imem_req_q;
  assign IMEM_ADDR = pc_q;
  assign PC        = pc_q;
  assign NPC       = npc_q;
  assign ID_INSTR  = id_instr_q;
  assign ID_PC     = id_pc_q;
  assign ID_VALID  = id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes expected post-edge state into
// a scoreboard queue, a monitor pops and compares entries when they fall due.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, LE, BR_TAKEN, NULLIFY, IMEM_READY;
  logic [31:0] TA, IMEM_DATA;
  logic        IMEM_REQ, ID_VALID;
  logic [31:0] IMEM_ADDR, PC, NPC, ID_INSTR, ID_PC;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .LE(LE), .BR_TAKEN(BR_TAKEN), .TA(TA),
    .NULLIFY(NULLIFY), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_DATA(IMEM_DATA), .IMEM_READY(IMEM_READY), .PC(PC), .NPC(NPC),
    .ID_INSTR(ID_INSTR), .ID_PC(ID_PC), .ID_VALID(ID_VALID)
  );

  typedef struct {
    int          due;
    logic        valid;
    logic [31:0] instr, idpc, pc, npc;
    logic        req;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int c);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, c, act, exp);
    end
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      while (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("ID_VALID",  {31'd0, ID_VALID}, {31'd0, e.valid}, cyc);
        chk("ID_INSTR",  ID_INSTR, e.instr, cyc);
        chk("ID_PC",     ID_PC,    e.idpc,  cyc);
        chk("PC",        PC,       e.pc,    cyc);
        chk("IMEM_ADDR", IMEM_ADDR, e.pc,   cyc);
        chk("NPC",       NPC,      e.npc,   cyc);
        chk("IMEM_REQ",  {31'd0, IMEM_REQ}, {31'd0, e.req}, cyc);
      end
    end
  end

  task automatic step(input logic r, input logic le_i, input logic br_i, input logic [31:0] ta_i,
                      input logic nul_i, input logic rdy_i, input logic [31:0] d,
                      input logic ev, input logic [31:0] ei, input logic [31:0] eidpc,
                      input logic [31:0] epc, input logic [31:0] enpc, input logic ereq);
    exp_t e;
    reset = r; LE = le_i; BR_TAKEN = br_i; TA = ta_i; NULLIFY = nul_i;
    IMEM_READY = rdy_i; IMEM_DATA = d;
    e.due = cyc + 1; e.valid = ev; e.instr = ei; e.idpc = eidpc;
    e.pc = epc; e.npc = enpc; e.req = ereq;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // fetch one real instruction with LE=1, READY=1
  task automatic run(input logic [31:0] d, input logic [31:0] idpc, input logic [31:0] epc, input logic [31:0] enpc);
    step(0, 1, 0, 0, 0, 1, d, 1, d, idpc, epc, enpc, 1);
  endtask

  task automatic do_reset();
    step(1, 1, 0, 0, 0, 1, 32'h1234_5678, 0, 0, 0, 0, 4, 1);
  endtask

  initial begin
    int budget;
    // reset state, held two cycles
    do_reset();
    do_reset();
    // sequential fetch
    run(32'hA000_0000, 0, 4, 8);
    run(32'hA000_0001, 4, 8, 12);
    run(32'hA000_0002, 8, 12, 16);
    // branch at PC=8 with delay slot
    do_reset();
    run(32'hA000_0000, 0, 4, 8);
    run(32'hA000_0001, 4, 8, 12);
    step(0, 1, 1, 32'h100, 0, 1, 32'hB000_0008, 1, 32'hB000_0008, 8, 12, 32'h100, 1);
    run(32'hB000_000C, 12, 32'h100, 32'h104);
    run(32'hB000_0100, 32'h100, 32'h104, 32'h108);
    // memory wait: three bubbles at PC=8
    do_reset();
    run(32'hA000_0000, 0, 4, 8);
    run(32'hA000_0001, 4, 8, 12);
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 4, 8, 12, 1);
    run(32'hC000_0008, 8, 12, 16);
    // stall with response in hand: HOLD
    do_reset();
    run(32'hA000_0000, 0, 4, 8);
    run(32'hA000_0001, 4, 8, 12);
    step(0, 0, 0, 0, 0, 1, 32'hE000_0008, 1, 32'hA000_0001, 4, 8, 12, 0);
    step(0, 0, 0, 0, 0, 1, 32'hBAD0_BAD0, 1, 32'hA000_0001, 4, 8, 12, 0);
    step(0, 1, 0, 0, 0, 0, 32'hBAD1_BAD1, 1, 32'hE000_0008, 8, 12, 16, 1);
    // nullify while stalled on fetch at 12
    step(0, 0, 0, 0, 1, 0, 32'h0,         1, 32'hE000_0008, 8, 12, 16, 1);
    step(0, 0, 0, 0, 0, 1, 32'hF000_000C, 1, 32'hE000_0008, 8, 12, 16, 0);
    step(0, 1, 0, 0, 0, 0, 32'h0,         0, 0, 12, 16, 20, 1);
    run(32'hF000_0010, 16, 20, 24);
    // bubble does not consume a pending squash
    step(0, 1, 0, 0, 1, 0, 32'h0,         0, 0, 16, 20, 24, 1);
    step(0, 1, 0, 0, 0, 1, 32'h6000_0014, 0, 0, 20, 24, 28, 1);
    run(32'h6000_0018, 24, 28, 32);
    // redirect latched while stalled, second BR_TAKEN overwrites target
    step(0, 0, 1, 32'h200, 0, 0, 32'h0, 1, 32'h6000_0018, 24, 28, 32, 1);
    step(0, 0, 1, 32'h300, 0, 0, 32'h0, 1, 32'h6000_0018, 24, 28, 32, 1);
    run(32'h7000_001C, 28, 32, 32'h300);
    run(32'h7000_0020, 32, 32'h300, 32'h304);
    // reach PC=0x40, enter WAIT, reset with response arriving
    step(0, 1, 1, 32'h40, 0, 1, 32'h8000_0300, 1, 32'h8000_0300, 32'h300, 32'h304, 32'h40, 1);
    run(32'h8000_0304, 32'h304, 32'h40, 32'h44);
    step(0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h304, 32'h40, 32'h44, 1);
    step(1, 1, 0, 0, 0, 1, 32'h5555_5555, 0, 0, 0, 0, 4, 1);
    run(32'h9000_0000, 0, 4, 8);
    // NPC wrap from 0xFFFF_FFFC to 0
    step(0, 1, 1, 32'hFFFF_FFF8, 0, 1, 32'h9000_0004, 1, 32'h9000_0004, 4, 8, 32'hFFFF_FFF8, 1);
    run(32'h9000_0008, 8, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
    run(32'h9000_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0);
    run(32'h9000_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h4);
    LE = 0; IMEM_READY = 0; BR_TAKEN = 0; NULLIFY = 0;
    budget = 10;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #3;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
